// File: rtl/carry_select_subtractor8_pipe.sv
// Two-stage 8-bit carry-select subtractor (a - b - bin) with valid/ready flow control.
// Stage 1 holds the low nibble and both high-nibble candidates; stage 2 selects and registers the result.
module carry_select_subtractor8_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef struct packed {
        logic [3:0] dl;
        logic       b4;
        logic [3:0] dh0;
        logic       bh0;
        logic [3:0] dh1;
        logic       bh1;
        logic       a7;
        logic       b7;
    } s1_t;

    // Nibble subtract via x + ~y + ~borrow_in; returns {borrow_out, difference}.
    function automatic logic [4:0] nib_sub(input logic [3:0] x, input logic [3:0] y, input logic bi);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, ~y} + {4'b0000, ~bi};
        return {~s[4], s[3:0]};
    endfunction

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;
    s1_t        s1_next;
    s1_t        s1;
    logic       s1_valid;
    logic       s2_load;
    logic       s1_adv;
    logic       in_fire;
    logic [3:0] sel_dh;
    logic       sel_bout;
    logic       sel_ovf;

    assign lo  = nib_sub(a[3:0], b[3:0], bin);
    assign hi0 = nib_sub(a[7:4], b[7:4], 1'b0);
    assign hi1 = nib_sub(a[7:4], b[7:4], 1'b1);

    always_comb begin
        s1_next     = '0;
        s1_next.dl  = lo[3:0];
        s1_next.b4  = lo[4];
        s1_next.dh0 = hi0[3:0];
        s1_next.bh0 = hi0[4];
        s1_next.dh1 = hi1[3:0];
        s1_next.bh1 = hi1[4];
        s1_next.a7  = a[7];
        s1_next.b7  = b[7];
    end

    // NOTE: in_ready depends only on state and out_ready, never on in_valid, so no loop can form through the producer.
    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    assign sel_dh   = s1.b4 ? s1.dh1 : s1.dh0;
    assign sel_bout = s1.b4 ? s1.bh1 : s1.bh0;
    assign sel_ovf  = (s1.a7 != s1.b7) && (sel_dh[3] != s1.a7);

    // NOTE: all state uses non-blocking assignments so S2 captures the pre-edge S1 content when both stages move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1       <= s1_next;
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff      <= 8'h00;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            diff      <= {sel_dh, s1.dl};
            bout      <= sel_bout;
            ovf       <= sel_ovf;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_carry_select_subtractor8_pipe.sv
// Self-checking bench: directed cases, streaming, backpressure, reset mid-stream and random stalls
// against an integer-arithmetic reference model and an in-order scoreboard.
module tb_carry_select_subtractor8_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    carry_select_subtractor8_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } res_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;
    res_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        res_t r;
        int   u;
        int   s;
        u    = int'(x) - int'(y) - int'(bi);
        s    = int'($signed(x)) - int'($signed(y)) - int'(bi);
        r.d  = u[7:0];
        r.bo = (u < 0);
        r.ov = (s < -128) || (s > 127);
        return r;
    endfunction

    // Scoreboard and hold checker, sampled on the falling edge (inputs are stable then).
    logic       stall_prev = 1'b0;
    logic [7:0] prev_diff;
    logic       prev_bout;
    logic       prev_ovf;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_diff", diff, prev_diff);
                check("hold_bout", bout, prev_bout);
                check("hold_ovf", ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra", 1, 0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_diff", diff, e.d);
                    check("sb_bout", bout, e.bo);
                    check("sb_ovf", ovf, e.ov);
                end
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
            stall_prev = out_valid && !out_ready;
            prev_diff  = diff;
            prev_bout  = bout;
            prev_ovf   = ovf;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operand set with an empty pipeline: result must appear after the second edge.
    task automatic directed(input string tag, input logic [7:0] x, input logic [7:0] y, input logic bi,
                            input logic [7:0] ed, input logic eb, input logic eo);
        a = x; b = y; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"}, ovf, eo);
        tick();
    endtask

    initial begin
        int base_out;
        rst = 1'b1; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 8'h00);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();
        check("post_rst_valid", out_valid, 0);

        directed("dir_0_1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        directed("dir_80_1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        directed("dir_10_1b", 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0);
        directed("dir_55_55b", 8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0);
        directed("dir_0_80", 8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1);

        // Streaming: back-to-back operands with the consumer always ready.
        base_out  = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); in_valid = 1'b1;
            check("stream_in_ready", in_ready, 1);
            tick();
            if (i > 0) check("stream_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("stream_count", n_out - base_out, 256);

        // Backpressure: two stages fill, third set is refused until the consumer returns.
        out_ready = 1'b0;
        a = 8'h20; b = 8'h05; bin = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'h07; b = 8'h09;
        check("bp_ready_one", in_ready, 1);
        tick();
        a = 8'h7F; b = 8'hFF;
        check("bp_full_ready", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
        check("bp_full_diff", diff, 8'h1B);
        check("bp_full_bout", bout, 0);
        repeat (3) begin
            tick();
            check("bp_stall_diff", diff, 8'h1B);
            check("bp_stall_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_rise", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_r2_diff", diff, 8'hFE);
        check("bp_r2_bout", bout, 1);
        check("bp_r2_ovf", ovf, 0);
        tick();
        check("bp_r3_diff", diff, 8'h80);
        check("bp_r3_bout", bout, 1);
        check("bp_r3_ovf", ovf, 1);
        tick();
        check("bp_drained", out_valid, 0);

        // Reset with both stages full must clear outputs without a clock edge.
        out_ready = 1'b0;
        a = 8'h3C; b = 8'h12; bin = 1'b1; in_valid = 1'b1;
        tick();
        a = 8'h99;
        tick();
        in_valid = 1'b0;
        check("mid_full_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_diff", diff, 8'h00);
        check("mid_rst_ready", in_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mid_no_stale", out_valid, 0);
        directed("mid_after", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1);

        // Random valid/ready over 10k cycles; the scoreboard checks order and hold.
        base_out = n_out;
        for (int i = 0; i < 10000; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("rand_sb_empty", exp_q.size(), 0);
        check("rand_some_out", (n_out - base_out) > 1000, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
